// File: rtl/uart_pkg.sv
// Shared types for the UART transmitter: FSM state encoding and parity mode codes.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    typedef logic [1:0] parity_mode_t;

    localparam parity_mode_t PAR_NONE = 2'b00;
    localparam parity_mode_t PAR_EVEN = 2'b01;
    localparam parity_mode_t PAR_ODD  = 2'b10;

    // Mode 11 is reserved and behaves like PAR_NONE.
    function automatic logic par_active(input parity_mode_t m);
        return (m == PAR_EVEN) || (m == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Show-ahead TX FIFO: rdata always presents the oldest entry; pointers wrap modulo DEPTH.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr, r_rptr;
    logic [AW:0]      r_count;
    logic             w_push, w_pop;

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign full   = (r_count == (AW+1)'(DEPTH));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign rdata  = r_mem[r_rptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= wdata;
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// FIFO-buffered UART transmitter: start, DATA_W bits LSB first, optional parity, STOP_BITS stops.
// Define UART_TX_PARITY_EN to build in the even/odd parity bit selected by parity_mode.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 5208,
    parameter int FIFO_DEPTH   = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    input  logic [DATA_W-1:0]             tx_data,
    input  logic [1:0]                    parity_mode,
    output logic                          TX_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          CountSig
);
    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam int            BW        = $clog2(DATA_W);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    tx_state_t         r_state, w_state_nxt;
    logic [CW-1:0]     r_cnt;
    logic [BW-1:0]     r_bit;
    logic [DATA_W-1:0] r_shift, w_shift_nxt, w_fifo_rdata;
    logic              r_tx, w_tx_nxt, r_rdy;
    logic              w_tick, w_push, w_pop, w_full, w_empty;
`ifdef UART_TX_PARITY_EN
    logic              r_par, r_par_en;
`else
    logic              w_unused_par;
    assign w_unused_par = ^parity_mode;
`endif

    // r_rdy holds tx_ready low through reset and the first edge after release.
    assign tx_ready = r_rdy && !w_full;
    assign w_push   = tx_valid && tx_ready;
    assign busy     = (r_state != IDLE);
    assign w_tick   = busy && (r_cnt == CNT_LAST);
    assign CountSig = w_tick;
    assign TX_out   = r_tx;

    uart_tx_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (w_push),
        .wdata   (tx_data),
        .pop     (w_pop),
        .rdata   (w_fifo_rdata),
        .full    (w_full),
        .empty   (w_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: if (!w_empty) begin
                w_pop       = 1'b1;
                w_state_nxt = START;
            end
            START: if (w_tick) w_state_nxt = DATA;
            DATA: if (w_tick && r_bit == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                w_state_nxt = r_par_en ? PARITY : STOP;
`else
                w_state_nxt = STOP;
`endif
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (w_tick) w_state_nxt = STOP;
`endif
            // Chain straight into the next frame when more data is waiting.
            STOP: if (w_tick && r_bit == STOP_LAST) begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = START;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_shift_nxt = r_shift;
        if (w_pop)                          w_shift_nxt = w_fifo_rdata;
        else if (w_tick && r_state == DATA) w_shift_nxt = r_shift >> 1;
    end

    // Line level is registered from next-state so TX_out never glitches on transitions or reset.
    always_comb begin
        w_tx_nxt = 1'b1;
        case (w_state_nxt)
            START:   w_tx_nxt = 1'b0;
            DATA:    w_tx_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  w_tx_nxt = r_par;
`endif
            default: w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_rdy   <= 1'b0;
        end else begin
            r_rdy   <= 1'b1;
            r_tx    <= w_tx_nxt;
            r_shift <= w_shift_nxt;
            if (w_pop || w_tick || !busy) r_cnt <= '0;
            else                          r_cnt <= r_cnt + 1'b1;
            if (w_pop || (w_tick && w_state_nxt != r_state)) r_bit <= '0;
            else if (w_tick)                                 r_bit <= r_bit + 1'b1;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_par    <= 1'b0;
            r_par_en <= 1'b0;
        end else if (w_pop) begin
            r_par    <= (^w_fifo_rdata) ^ (parity_mode == PAR_ODD);
            r_par_en <= par_active(parity_mode);
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed self-checking bench for uart_tx_cfg (DATA_W=8, CLKS_PER_BIT=4, FIFO_DEPTH=4, STOP_BITS=1).
module tb_uart_tx_cfg;
    localparam int DW = 8, CPB = 4, FD = 4, SB = 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          tx_valid = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic [1:0]    parity_mode = 2'b00;
    logic          tx_ready, TX_out, busy, CountSig;
    logic [2:0]    fifo_count;
    int            n_tests = 0;
    int            n_fail = 0;

    always #5 clk = ~clk;

    uart_tx_cfg #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(FD), .STOP_BITS(SB)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .parity_mode (parity_mode),
        .TX_out      (TX_out),
        .busy        (busy),
        .fifo_count  (fifo_count),
        .CountSig    (CountSig)
    );

    // Bit b (0 = start, 9 = stop) of a no-parity 8N1 frame carrying d.
    function automatic logic fbit(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return d[b-1];
    endfunction

    task automatic push(input logic [7:0] d);
        @(negedge clk); tx_valid = 1'b1; tx_data = d;
        @(negedge clk); tx_valid = 1'b0;
    endtask

    // Waits for busy, then records TX_out once per cycle until busy falls (bounded by maxc).
    task automatic capture(input int maxc, output int nb, output int np, output logic [255:0] ln);
        int t = 0;
        nb = 0; np = 0; ln = '0;
        while (!busy && t < maxc) begin @(negedge clk); t++; end
        while (busy && t < maxc && nb < 256) begin
            ln[nb] = TX_out;
            if (CountSig) np++;
            nb++;
            @(negedge clk); t++;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if (TX_out !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", TX_out); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (CountSig !== 1'b0) begin n_fail++; $display("FAIL reset_countsig: got %b want 0", CountSig); end
        n_tests++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        n_tests++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", tx_ready); end
        reset_n = 1'b1;
        #1;
        n_tests++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL ready_before_edge: got %b want 0", tx_ready); end
        @(negedge clk);
        n_tests++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_edge: got %b want 1", tx_ready); end
    endtask

    task automatic test_single;
        int nb, np, bad;
        logic [255:0] ln;
        logic [15:0]  e;
        e = 16'h02AA;  // 0,1,0,1,0,1,0,1,0,1 sent from bit 0 upward
        parity_mode = 2'b00;
        push(8'h55);
        capture(200, nb, np, ln);
        bad = 0;
        for (int c = 0; c < 40; c++) if (ln[c] !== e[c/4]) bad++;
        n_tests++; if (nb !== 40) begin n_fail++; $display("FAIL single_busy_cycles: got %0d want 40", nb); end
        n_tests++; if (np !== 10) begin n_fail++; $display("FAIL single_countsig: got %0d want 10", np); end
        n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL single_waveform: %0d bad cycles want 0", bad); end
        n_tests++; if (TX_out !== 1'b1) begin n_fail++; $display("FAIL single_idle_line: got %b want 1", TX_out); end
    endtask

    task automatic test_parity;
        int nb, np, bad, nbits;
        logic [255:0] ln;
        logic [15:0]  e_even, e_odd;
`ifdef UART_TX_PARITY_EN
        e_even = 16'h054A; e_odd = 16'h074A; nbits = 11;
`else
        e_even = 16'h034A; e_odd = 16'h034A; nbits = 10;
`endif
        // Mode flips right after the pop; the frame must keep the even setting.
        parity_mode = 2'b01;
        push(8'hA5);
        @(negedge clk);
        parity_mode = 2'b10;
        capture(200, nb, np, ln);
        bad = 0;
        for (int c = 0; c < nbits*4; c++) if (ln[c] !== e_even[c/4]) bad++;
        n_tests++; if (nb !== nbits*4) begin n_fail++; $display("FAIL even_cycles: got %0d want %0d", nb, nbits*4); end
        n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL even_waveform: %0d bad cycles want 0", bad); end
        push(8'hA5);
        capture(200, nb, np, ln);
        bad = 0;
        for (int c = 0; c < nbits*4; c++) if (ln[c] !== e_odd[c/4]) bad++;
        n_tests++; if (nb !== nbits*4) begin n_fail++; $display("FAIL odd_cycles: got %0d want %0d", nb, nbits*4); end
        n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL odd_waveform: %0d bad cycles want 0", bad); end
        n_tests++; if (np !== nbits) begin n_fail++; $display("FAIL odd_countsig: got %0d want %0d", np, nbits); end
    endtask

    task automatic test_back_to_back;
        int nb, np, bad;
        logic [255:0] ln;
        logic [7:0]   d [6];
        d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44; d[4] = 8'h55; d[5] = 8'h66;
        parity_mode = 2'b00;
        fork
            begin
                @(negedge clk); tx_valid = 1'b1; tx_data = d[0];
                for (int i = 1; i < 6; i++) begin
                    @(negedge clk); tx_data = d[i];
                    if (i == 5) begin
                        n_tests++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL b2b_full_count: got %0d want 4", fifo_count); end
                        n_tests++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_low: got %b want 0", tx_ready); end
                    end
                end
                @(negedge clk); tx_valid = 1'b0;
                n_tests++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL b2b_reject_full: got %0d want 4", fifo_count); end
            end
            capture(400, nb, np, ln);
        join
        bad = 0;
        for (int c = 0; c < 200; c++) if (ln[c] !== fbit(d[c/40], (c%40)/4)) bad++;
        n_tests++; if (nb !== 200) begin n_fail++; $display("FAIL b2b_busy_cycles: got %0d want 200", nb); end
        n_tests++; if (np !== 50) begin n_fail++; $display("FAIL b2b_countsig: got %0d want 50", np); end
        n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL b2b_waveform: %0d bad cycles want 0", bad); end
        n_tests++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL b2b_drained: got %0d want 0", fifo_count); end
    endtask

    task automatic test_reset_mid;
        int stray;
        parity_mode = 2'b00;
        @(negedge clk); tx_valid = 1'b1; tx_data = 8'h0F;
        @(negedge clk); tx_data = 8'hAA;
        @(negedge clk); tx_data = 8'hBB;
        @(negedge clk); tx_valid = 1'b0;
        n_tests++; if (fifo_count !== 3'd2) begin n_fail++; $display("FAIL mid_queued: got %0d want 2", fifo_count); end
        // Land in data bit 4 of 0x0F, which drives the line low.
        repeat (20) @(negedge clk);
        n_tests++; if (TX_out !== 1'b0) begin n_fail++; $display("FAIL mid_bit4_low: got %b want 0", TX_out); end
        reset_n = 1'b0;
        #1;
        n_tests++; if (TX_out !== 1'b1) begin n_fail++; $display("FAIL mid_reset_tx: got %b want 1", TX_out); end
        n_tests++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL mid_reset_count: got %0d want 0", fifo_count); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
        @(negedge clk); reset_n = 1'b1;
        stray = 0;
        repeat (60) begin
            @(negedge clk);
            if (busy !== 1'b0 || TX_out !== 1'b1) stray++;
        end
        n_tests++; if (stray !== 0) begin n_fail++; $display("FAIL mid_no_more_frames: %0d active cycles want 0", stray); end
        n_tests++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready_back: got %b want 1", tx_ready); end
    endtask

    task automatic test_wrap;
        int nb, np, bad;
        logic [255:0] ln;
        logic [7:0]   d [6];
        d[0] = 8'h01; d[1] = 8'h80; d[2] = 8'h3C; d[3] = 8'hC3; d[4] = 8'h5A; d[5] = 8'hE7;
        parity_mode = 2'b00;
        fork
            begin
                @(negedge clk); tx_valid = 1'b1; tx_data = d[0];
                @(negedge clk); tx_data = d[1];
                @(negedge clk); tx_data = d[2];
                @(negedge clk); tx_valid = 1'b0;
                n_tests++; if (fifo_count !== 3'd2) begin n_fail++; $display("FAIL wrap_pre_count: got %0d want 2", fifo_count); end
                // Last cycle of frame 0's stop bit: the next edge both pops and pushes.
                repeat (38) @(negedge clk);
                n_tests++; if (CountSig !== 1'b1) begin n_fail++; $display("FAIL wrap_stop_tick: got %b want 1", CountSig); end
                tx_valid = 1'b1; tx_data = d[3];
                @(negedge clk); tx_data = d[4];
                n_tests++; if (fifo_count !== 3'd2) begin n_fail++; $display("FAIL wrap_push_pop: got %0d want 2", fifo_count); end
                @(negedge clk); tx_data = d[5];
                @(negedge clk); tx_valid = 1'b0;
                n_tests++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL wrap_full: got %0d want 4", fifo_count); end
            end
            capture(600, nb, np, ln);
        join
        bad = 0;
        for (int c = 0; c < 240; c++) if (ln[c] !== fbit(d[c/40], (c%40)/4)) bad++;
        n_tests++; if (nb !== 240) begin n_fail++; $display("FAIL wrap_busy_cycles: got %0d want 240", nb); end
        n_tests++; if (np !== 60) begin n_fail++; $display("FAIL wrap_countsig: got %0d want 60", np); end
        n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL wrap_order: %0d bad cycles want 0", bad); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_parity();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning data bits per frame (legal 5..9).
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 5208, meaning clk cycles per bit period (50 MHz / 9600 baud; legal >= 2).
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 8, meaning TX FIFO entries (power of two, >= 2).
REQ-004 The block SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame (legal 1 or 2).
REQ-005 The block SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset_n, input, 1, meaning an asynchronous, active-low reset.
REQ-007 The block SHALL have port tx_valid, input, 1, meaning tx_data is offered for enqueue.
REQ-008 The block SHALL have port tx_ready, output, 1, meaning the FIFO can accept data (= not full).
REQ-009 The block SHALL have port tx_data, input, DATA_W, meaning the frame payload, sent LSB first.
REQ-010 The block SHALL have port parity_mode, input, 2, meaning 00 none, 01 even, 10 odd, 11 treated as none.
REQ-011 The block SHALL have port TX_out, output, 1, meaning the serial line (idle high).
REQ-012 The block SHALL have port busy, output, 1, meaning high while the FSM is not IDLE.
REQ-013 The block SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1, meaning occupied FIFO entries.
REQ-014 The block SHALL have port CountSig, output, 1, meaning a one-cycle pulse on the last clk of every bit period.

Function
REQ-015 A push SHALL occur on a clk edge where tx_valid and tx_ready are both high; otherwise tx_data is ignored.
REQ-016 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP and move IDLE->START->DATA->(PARITY)->STOP->IDLE or START.
REQ-017 In IDLE with fifo_count > 0, the FSM SHALL pop one entry and enter START on the next edge; TX_out goes low that cycle.
REQ-018 Each state SHALL hold TX_out for exactly CLKS_PER_BIT cycles per bit: START 0, DATA bits LSB first, PARITY the computed bit, STOP 1.
REQ-019 DATA SHALL last DATA_W bit periods and STOP SHALL last STOP_BITS bit periods.
REQ-020 The PARITY state SHALL be entered only when parity_mode is 01 or 10, with even = XOR of the data bits and odd = its inverse.
REQ-021 parity_mode and the popped data SHALL be latched at the pop and SHALL NOT change within the frame.
REQ-022 At the end of STOP, if the FIFO is non-empty, the FSM SHALL pop and enter START directly, with no idle cycle between frames.
REQ-023 A simultaneous push and pop SHALL both take effect and leave fifo_count unchanged.
REQ-024 A push while full SHALL be impossible because tx_ready is low; the FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-025 CountSig SHALL pulse only while busy is high, and the bit counter SHALL restart at every state transition.

Reset
REQ-026 When reset_n is low, the block SHALL immediately (asynchronously) drive TX_out=1, busy=0, CountSig=0, fifo_count=0 and tx_ready=0, with FSM=IDLE and pointers=0.
REQ-027 tx_ready SHALL go high on the first clk edge after reset_n deasserts.
REQ-028 A reset during a frame SHALL abort the frame and flush the FIFO, with no glitch to 0 on TX_out.

Configuration
REQ-029 With UART_TX_PARITY_EN defined, parity SHALL operate per REQ-020.
REQ-030 Without UART_TX_PARITY_EN, the PARITY state and parity logic SHALL be absent, parity_mode SHALL remain a port but be ignored, and frames SHALL have no parity bit.

Structure
REQ-031 Package uart_pkg SHALL hold the tx_state_t enum, the parity_mode_t typedef and the PAR_NONE/PAR_EVEN/PAR_ODD constants.
REQ-032 The FIFO SHALL be the sub-module uart_tx_fifo (parameters WIDTH and DEPTH; ports push/pop/full/empty/count), and the FSM, baud counter and shifter SHALL stay in uart_tx_cfg.

Verification (bench: DATA_W=8, CLKS_PER_BIT=4, FIFO_DEPTH=4, STOP_BITS=1, UART_TX_PARITY_EN defined)
REQ-033 Push 0x55 with parity_mode=00 -> TX_out SHALL be 0,1,0,1,0,1,0,1,0,1, each 4 cycles; busy SHALL be high for 40 cycles, with 10 CountSig pulses.
REQ-034 Push 0xA5 with parity 01 and then 10 -> the parity bit SHALL be 0 (even) then 1 (odd), and each frame SHALL be 11 bits / 44 cycles.
REQ-035 Hold tx_valid for 6 cycles while the line is idle -> 5 entries SHALL be accepted (1 popped at once plus 4 stored), tx_ready SHALL fall, and the frames SHALL be sent back-to-back with no idle high between STOP and START.
REQ-036 Assert reset_n=0 mid-DATA of frame 0x0F with 2 entries queued -> TX_out=1 at once, fifo_count=0, and no further frames after release.
REQ-037 Push and pop in the same cycle with fifo_count=2 -> fifo_count SHALL stay 2, and data order SHALL be preserved across a pointer wrap.
